// File: rtl/fetch_pred_pc_pkg.sv
// rtl/fetch_pred_pc_pkg.sv - shared icodes and types for fetch-side PC prediction
package fetch_pred_pc_pkg;

    localparam logic [3:0] IOPQ  = 4'h6;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef logic [63:0] addr_t;

    typedef enum logic [1:0] {
        SEL_VALP = 2'd0,
        SEL_VALC = 2'd1,
        SEL_RAS  = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pred_pc_ras_stack.sv
// rtl/fetch_pred_pc_ras_stack.sv - speculative return-address stack with checkpoint restore
module ras_stack
    import fetch_pred_pc_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [63:0]      push_data_i,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [PTR_W:0]   restore_cnt_i,
    output logic [63:0]      top_data_o,
    output logic             top_vld_o,
    output logic [PTR_W-1:0] ptr_o,
    output logic [PTR_W:0]   cnt_o
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

    addr_t            mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, base_ptr;
    logic [PTR_W:0]   cnt_q, cnt_d, base_cnt;

    // The restored checkpoint is the base that this cycle's push/pop builds on.
    assign base_ptr   = restore_i ? restore_ptr_i : ptr_q;
    assign base_cnt   = restore_i ? restore_cnt_i : cnt_q;
    assign top_vld_o  = (base_cnt != '0);
    assign top_data_o = mem_q[base_ptr - PTR_W'(1)];
    assign ptr_o      = ptr_q;
    assign cnt_o      = cnt_q;

    always_comb begin
        ptr_d = base_ptr;
        cnt_d = base_cnt;
        if (en_i && push_i) begin
            ptr_d = base_ptr + PTR_W'(1);
            cnt_d = (base_cnt == CNT_FULL) ? CNT_FULL : base_cnt + (PTR_W+1)'(1);
        end else if (en_i && pop_i && top_vld_o) begin
            ptr_d = base_ptr - PTR_W'(1);
            cnt_d = base_cnt - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // A full stack simply overwrites the oldest slot; entries need no reset.
    always_ff @(posedge clk_i) begin
        if (en_i && push_i) begin
            mem_q[base_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_pred_pc.sv
// rtl/fetch_pred_pc.sv - F pipeline register and next-PC prediction
module fetch_pred_pc
    import fetch_pred_pc_pkg::*;
#(
    parameter int          RAS_DEPTH = 8,
    parameter int          PTR_W     = 3,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       f_icode_i,
    input  logic [63:0]      f_valC_i,
    input  logic [63:0]      f_valP_i,
    input  logic             f_valid_i,
    input  logic             F_stall_i,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [PTR_W:0]   restore_cnt_i,
    output logic [63:0]      F_predPC_o,
    output logic             f_ret_pred_o,
    output logic [PTR_W-1:0] ras_ptr_o,
    output logic [PTR_W:0]   ras_cnt_o
);

    addr_t   pred_q, pred_d;
    addr_t   ras_top;
    logic    ras_vld;
    logic    is_call, is_ret, fetch_en;
    pc_sel_e sel;

    assign is_call      = (f_icode_i == ICALL);
    assign is_ret       = (f_icode_i == IRET);
    assign fetch_en     = f_valid_i && !F_stall_i;
    assign f_ret_pred_o = is_ret && f_valid_i && ras_vld;

    ras_stack #(
        .RAS_DEPTH(RAS_DEPTH),
        .PTR_W    (PTR_W)
    ) u_ras (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (fetch_en),
        .push_i       (is_call),
        .pop_i        (is_ret),
        .push_data_i  (f_valP_i),
        .restore_i    (restore_i),
        .restore_ptr_i(restore_ptr_i),
        .restore_cnt_i(restore_cnt_i),
        .top_data_o   (ras_top),
        .top_vld_o    (ras_vld),
        .ptr_o        (ras_ptr_o),
        .cnt_o        (ras_cnt_o)
    );

    // An empty-stack ret falls back to valP; the hazard unit stalls fetch for it.
    always_comb begin
        sel = SEL_VALP;
        if (f_icode_i == IJXX || is_call) begin
            sel = SEL_VALC;
        end else if (f_ret_pred_o) begin
            sel = SEL_RAS;
        end
    end

    always_comb begin
        pred_d = pred_q;
        if (fetch_en) begin
            case (sel)
                SEL_VALC: pred_d = f_valC_i;
                SEL_RAS:  pred_d = ras_top;
                default:  pred_d = f_valP_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_q <= RESET_PC;
        end else begin
            pred_q <= pred_d;
        end
    end

    assign F_predPC_o = pred_q;

endmodule

// File: tb/tb_fetch_pred_pc.sv
// tb/tb_fetch_pred_pc.sv - directed vector bench for fetch_pred_pc
module tb_fetch_pred_pc;
    import fetch_pred_pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic [63:0] valc, valp;
    logic        valid, stall, restore;
    logic [2:0]  rptr;
    logic [3:0]  rcnt;
    logic [63:0] pred_pc;
    logic        ret_pred;
    logic [2:0]  ras_ptr;
    logic [3:0]  ras_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pred_pc #(.RAS_DEPTH(8), .PTR_W(3), .RESET_PC(64'h0)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .f_icode_i    (icode),
        .f_valC_i     (valc),
        .f_valP_i     (valp),
        .f_valid_i    (valid),
        .F_stall_i    (stall),
        .restore_i    (restore),
        .restore_ptr_i(rptr),
        .restore_cnt_i(rcnt),
        .F_predPC_o   (pred_pc),
        .f_ret_pred_o (ret_pred),
        .ras_ptr_o    (ras_ptr),
        .ras_cnt_o    (ras_cnt)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        valid;
        logic        stall;
        logic        restore;
        logic [2:0]  rptr;
        logic [3:0]  rcnt;
        logic        exp_ret;
        logic [63:0] exp_pc;
        logic [2:0]  exp_ptr;
        logic [3:0]  exp_cnt;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                       input logic v, input logic s, input logic r, input logic [2:0] rp,
                       input logic [3:0] rc, input logic er, input logic [63:0] epc,
                       input logic [2:0] ept, input logic [3:0] ect, input string nm);
        vec_t t;
        t.icode = ic; t.valc = c; t.valp = p; t.valid = v; t.stall = s;
        t.restore = r; t.rptr = rp; t.rcnt = rc; t.exp_ret = er; t.exp_pc = epc;
        t.exp_ptr = ept; t.exp_cnt = ect; t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; icode = IOPQ; valc = '0; valp = '0; valid = 1'b0;
        stall = 1'b0; restore = 1'b0; rptr = '0; rcnt = '0;

        // Basic flow, call/ret, empty ret, invalid and stalled fetch.
        add(IOPQ,  64'h0,   64'h0A, 1, 0, 0, 0, 0, 0, 64'h0A,  0, 0, "seq");
        add(IJXX,  64'h100, 64'h14, 1, 0, 0, 0, 0, 0, 64'h100, 0, 0, "jxx");
        add(ICALL, 64'h200, 64'h30, 1, 0, 0, 0, 0, 0, 64'h200, 1, 1, "call");
        add(IRET,  64'h0,   64'h31, 1, 0, 0, 0, 0, 1, 64'h30,  0, 0, "ret");
        add(IRET,  64'h0,   64'h40, 1, 0, 0, 0, 0, 0, 64'h40,  0, 0, "ret_empty");
        add(ICALL, 64'h99,  64'h41, 0, 0, 0, 0, 0, 0, 64'h40,  0, 0, "invalid");
        add(ICALL, 64'h300, 64'h44, 1, 1, 0, 0, 0, 0, 64'h40,  0, 0, "stall_call");
        // Nine calls overflow the 8-deep stack; slot 0 is overwritten by 0x18.
        for (int i = 0; i < 9; i++)
            add(ICALL, 64'h500, 64'h10 + 64'(i), 1, 0, 0, 0, 0, 0, 64'h500,
                3'((i + 1) % 8), 4'((i + 1 > 8) ? 8 : i + 1), "ovf_call");
        for (int k = 1; k <= 8; k++)
            add(IRET, 64'h0, 64'h80, 1, 0, 0, 0, 0, 1, 64'h19 - 64'(k),
                3'((9 - k) % 8), 4'(8 - k), "ovf_ret");
        add(IRET,  64'h0,   64'h88, 1, 0, 0, 0, 0, 0, 64'h88,  1, 0, "underflow");
        // Correct-path calls, wrong-path calls, then restore with a call on top.
        add(ICALL, 64'h600, 64'h60, 1, 0, 0, 0, 0, 0, 64'h600, 2, 1, "cp_call0");
        add(ICALL, 64'h600, 64'h61, 1, 0, 0, 0, 0, 0, 64'h600, 3, 2, "cp_call1");
        add(ICALL, 64'h610, 64'h70, 1, 0, 0, 0, 0, 0, 64'h610, 4, 3, "wp_call0");
        add(ICALL, 64'h610, 64'h71, 1, 0, 0, 0, 0, 0, 64'h610, 5, 4, "wp_call1");
        add(ICALL, 64'h700, 64'h50, 1, 0, 1, 3, 2, 0, 64'h700, 4, 3, "restore_call");
        add(IRET,  64'h0,   64'h90, 1, 0, 0, 0, 0, 1, 64'h50,  3, 2, "restore_ret0");
        add(IRET,  64'h0,   64'h91, 1, 0, 0, 0, 0, 1, 64'h61,  2, 1, "restore_ret1");
        // Restore to an empty checkpoint makes the same-cycle ret unpredicted.
        add(IRET,  64'h0,   64'h80, 1, 0, 1, 5, 0, 0, 64'h80,  5, 0, "restore_ret_empty");
        add(ICALL, 64'h900, 64'h84, 1, 1, 1, 6, 4, 0, 64'h80,  6, 4, "stall_restore");

        #12;
        check64("reset_pc",  pred_pc, 64'h0);
        check64("reset_ptr", 64'(ras_ptr), 64'h0);
        check64("reset_cnt", 64'(ras_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            icode = vecs[i].icode; valc = vecs[i].valc; valp = vecs[i].valp;
            valid = vecs[i].valid; stall = vecs[i].stall; restore = vecs[i].restore;
            rptr = vecs[i].rptr; rcnt = vecs[i].rcnt;
            #1;
            check64({vecs[i].name, "_retpred"}, 64'(ret_pred), 64'(vecs[i].exp_ret));
            @(posedge clk);
            #1;
            check64({vecs[i].name, "_pc"},  pred_pc, vecs[i].exp_pc);
            check64({vecs[i].name, "_ptr"}, 64'(ras_ptr), 64'(vecs[i].exp_ptr));
            check64({vecs[i].name, "_cnt"}, 64'(ras_cnt), 64'(vecs[i].exp_cnt));
        end

        // Asynchronous reset mid-cycle, away from any clock edge.
        @(negedge clk);
        restore = 1'b0; stall = 1'b0; valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check64("async_reset_pc",  pred_pc, 64'h0);
        check64("async_reset_cnt", 64'(ras_cnt), 64'h0);
        check64("async_reset_ptr", 64'(ras_ptr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        icode = IOPQ; valp = 64'h0A; valid = 1'b1;
        @(posedge clk);
        #1;
        check64("post_reset_seq", pred_pc, 64'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
